// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the UART receiver and transmitter:
//   - parity_mode encodings (PAR_ODD / PAR_EVEN / PAR_MARK / PAR_SPACE)
//   - the frame FSM state encoding
//   - baud_div(): 16x oversample divisor for each baud_sel code
//   - parity_bit(): expected parity bit for a character
// No ports; import with `import uart_pkg::*;`.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_RATE = 16;
    localparam int          DIV_W           = 16;

    localparam logic [1:0] PAR_ODD   = 2'b11;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_MARK  = 2'b01;
    localparam logic [1:0] PAR_SPACE = 2'b00;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } uart_state_t;

    // Baud rate for each baud_sel code.
    function automatic int unsigned baud_rate(input logic [2:0] baud_sel);
        int unsigned rate;
        case (baud_sel)
            3'd0:    rate = 9600;
            3'd1:    rate = 19200;
            3'd2:    rate = 38400;
            3'd3:    rate = 57600;
            3'd4:    rate = 115200;
            3'd5:    rate = 230400;
            3'd6:    rate = 460800;
            default: rate = 921600;
        endcase
        return rate;
    endfunction

    // Rounded clock divisor producing one oversample tick. Meant to be
    // evaluated at elaboration time into a constant table; clamped to 1 so a
    // very slow clock still produces ticks.
    function automatic logic [DIV_W-1:0] baud_div(
        input int unsigned clk_freq_hz,
        input logic [2:0]  baud_sel,
        input int unsigned oversample = OVERSAMPLE_RATE
    );
        int unsigned den;
        int unsigned quo;
        den = oversample * baud_rate(baud_sel);
        quo = (clk_freq_hz + den / 2) / den;
        if (quo == 0) begin
            quo = 1;
        end
        return DIV_W'(quo);
    endfunction

    // Expected parity bit for an 8-bit character. In 7-bit mode the caller
    // passes bit 7 as zero, so it does not disturb the result.
    function automatic logic parity_bit(input logic [1:0] mode, input logic [7:0] bits);
        logic p;
        case (mode)
            PAR_ODD:  p = ~^bits;
            PAR_EVEN: p = ^bits;
            PAR_MARK: p = 1'b1;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
// Free-running divisor counter emitting a one-clock oversample tick every
// `div` clocks. A synchronous clear restarts the count so the tick phase can
// be aligned to an external event (the start edge in the receiver).
// Ports:
//   clk   in  1      system clock
//   rst   in  1      asynchronous active-low reset
//   clear in  1      synchronous restart of the count; no tick while high
//   div   in  DIV_W  clocks per tick (>= 1)
//   tick  out 1      one-clock pulse, first one `div` clocks after clear drops
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    // The >= compare keeps the counter bounded if div shrinks while running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count >= div - 1'b1) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + 1'b1;
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// UART receiver: 16x oversampling, 7/8 data bits LSB-first, optional parity
// (odd/even/mark/space), 1 or 2 stop bits. Each character is presented with a
// one-cycle valid strobe plus held parity and framing error flags.
// Ports:
//   clk           in  1  system clock
//   rst           in  1  asynchronous active-low reset
//   en            in  1  receiver enable; low aborts any frame
//   baud_sel      in  3  baud rate code (9600 .. 921600)
//   data_size     in  1  0: 7 data bits, 1: 8 data bits
//   parity_en     in  1  parity bit present after the data
//   parity_mode   in  2  11 odd, 10 even, 01 mark, 00 space
//   stop_bit_size in  1  0: 1 stop bit, 1: 2 stop bits
//   rx            in  1  serial line, idle high, asynchronous
//   data          out 8  last character (bit 7 zero in 7-bit mode)
//   valid         out 1  one-cycle strobe when data/flags are updated
//   parity_error  out 1  parity mismatch on the last character
//   frame_error   out 1  a stop bit of the last character sampled low
//   busy          out 1  frame in progress
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned OVERSAMPLE  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] baud_sel,
    input  logic       data_size,
    input  logic       parity_en,
    input  logic [1:0] parity_mode,
    input  logic       stop_bit_size,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_error,
    output logic       frame_error,
    output logic       busy
);

    localparam int              OS_W    = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    localparam logic [DIV_W-1:0] DIV_TABLE [8] = '{
        baud_div(CLK_FREQ_HZ, 3'd0, OVERSAMPLE),
        baud_div(CLK_FREQ_HZ, 3'd1, OVERSAMPLE),
        baud_div(CLK_FREQ_HZ, 3'd2, OVERSAMPLE),
        baud_div(CLK_FREQ_HZ, 3'd3, OVERSAMPLE),
        baud_div(CLK_FREQ_HZ, 3'd4, OVERSAMPLE),
        baud_div(CLK_FREQ_HZ, 3'd5, OVERSAMPLE),
        baud_div(CLK_FREQ_HZ, 3'd6, OVERSAMPLE),
        baud_div(CLK_FREQ_HZ, 3'd7, OVERSAMPLE)
    };

    uart_state_t state;
    uart_state_t next_state;

    logic             rx_meta;
    logic             rx_s;
    logic             tick;
    logic             tick_clear;
    logic [DIV_W-1:0] div;
    logic [OS_W-1:0]  os_cnt;
    logic             sample;
    logic [2:0]       bit_cnt;
    logic             last_bit;
    logic [7:0]       shreg;
    logic             par_acc;
    logic             frm_acc;
    logic             armed;
    logic             start_frame;
    logic             finish;
    logic             abort;

    logic [2:0]       cfg_baud;
    logic             cfg_size;
    logic             cfg_pen;
    logic [1:0]       cfg_pmode;
    logic             cfg_stop2;

    // Two-flop synchronizer. It resets low so that, after reset, the line has
    // to be seen high before start detection can arm.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b0;
            rx_s    <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Holding the tick counter clear throughout IDLE restarts its phase on the
    // cycle the start edge is accepted.
    assign tick_clear = (state == IDLE);
    assign div        = DIV_TABLE[cfg_baud];

    uart_baud_tick u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (tick_clear),
        .div   (div),
        .tick  (tick)
    );

    // The start bit is sampled half a bit in; every later sample falls a full
    // bit after the previous one.
    assign sample   = tick && ((state == START) ? (os_cnt == OS_MID) : (os_cnt == OS_LAST));
    assign last_bit = (bit_cnt == (cfg_size ? 3'd7 : 3'd6));
    assign abort    = (state != IDLE) && !en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        start_frame = 1'b0;
        finish      = 1'b0;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (en && armed && !rx_s) begin
                        next_state  = START;
                        start_frame = 1'b1;
                    end
                end
                START: begin
                    if (sample) begin
                        next_state = rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (sample && last_bit) begin
                        next_state = cfg_pen ? PARITY : STOP1;
                    end
                end
                PARITY: begin
                    if (sample) begin
                        next_state = STOP1;
                    end
                end
                STOP1: begin
                    if (sample) begin
                        if (cfg_stop2) begin
                            next_state = STOP2;
                        end else begin
                            next_state = IDLE;
                            finish     = 1'b1;
                        end
                    end
                end
                STOP2: begin
                    if (sample) begin
                        next_state = IDLE;
                        finish     = 1'b1;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            os_cnt <= '0;
        end else if (state == IDLE || sample) begin
            os_cnt <= '0;
        end else if (tick) begin
            os_cnt <= os_cnt + 1'b1;
        end
    end

    // Frame configuration is frozen at the start edge so mid-frame changes on
    // the inputs cannot corrupt the character being received.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_baud  <= '0;
            cfg_size  <= 1'b0;
            cfg_pen   <= 1'b0;
            cfg_pmode <= '0;
            cfg_stop2 <= 1'b0;
        end else if (start_frame) begin
            cfg_baud  <= baud_sel;
            cfg_size  <= data_size;
            cfg_pen   <= parity_en;
            cfg_pmode <= parity_mode;
            cfg_stop2 <= stop_bit_size;
        end
    end

    // Data bits land at their own index in a cleared register, which leaves
    // bit 7 at zero for 7-bit characters and feeds parity directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            par_acc <= 1'b0;
            frm_acc <= 1'b0;
        end else if (start_frame) begin
            shreg   <= '0;
            bit_cnt <= '0;
            par_acc <= 1'b0;
            frm_acc <= 1'b0;
        end else if (sample) begin
            case (state)
                DATA: begin
                    shreg[bit_cnt] <= rx_s;
                    bit_cnt        <= bit_cnt + 1'b1;
                end
                PARITY: par_acc <= rx_s ^ parity_bit(cfg_pmode, shreg);
                STOP1, STOP2: begin
                    if (!rx_s) begin
                        frm_acc <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Once a frame has finished or been aborted, the line must go high before
    // another start is accepted; a held-low break then yields one character.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed <= 1'b0;
        end else if (finish || abort) begin
            armed <= 1'b0;
        end else if (state == IDLE && rx_s) begin
            armed <= 1'b1;
        end
    end

    // The final stop sample is still in rx_s on the finishing edge, so it is
    // folded into the frame error here rather than through frm_acc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data         <= '0;
            valid        <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            valid <= finish;
            if (finish) begin
                data         <= shreg;
                parity_error <= par_acc;
                frame_error  <= frm_acc | ~rx_s;
            end
        end
    end

    // busy covers the valid cycle so it always drops after the strobe.
    assign busy = (state != IDLE) || valid;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [2:0] baud_sel = 3'd7;
    logic       data_size = 1'b1;
    logic       parity_en = 1'b0;
    logic [1:0] parity_mode = 2'b00;
    logic       stop_bit_size = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       parity_error;
    logic       frame_error;
    logic       busy;

    int total = 0;
    int bad = 0;

    logic [7:0] exp_data[$];
    logic       exp_pe[$];
    logic       exp_fe[$];
    logic [7:0] got_data[$];
    logic       got_pe[$];
    logic       got_fe[$];
    logic       got_busy_at[$];
    logic       got_busy_after[$];
    logic       got_wide[$];

    uart_rx #(.CLK_FREQ_HZ(100_000_000), .OVERSAMPLE(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .baud_sel      (baud_sel),
        .data_size     (data_size),
        .parity_en     (parity_en),
        .parity_mode   (parity_mode),
        .stop_bit_size (stop_bit_size),
        .rx            (rx),
        .data          (data),
        .valid         (valid),
        .parity_error  (parity_error),
        .frame_error   (frame_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Collects every delivered character, plus busy and the strobe on the cycle after.
    initial begin
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                got_data.push_back(data);
                got_pe.push_back(parity_error);
                got_fe.push_back(frame_error);
                got_busy_at.push_back(busy);
                @(negedge clk);
                got_wide.push_back(valid);
                got_busy_after.push_back(busy);
            end
        end
    end

    // Nominal line bit time in ns for a baud code.
    function automatic int bit_ns(input int sel);
        int rate;
        case (sel)
            0: rate = 9600;
            1: rate = 19200;
            2: rate = 38400;
            3: rate = 57600;
            4: rate = 115200;
            5: rate = 230400;
            6: rate = 460800;
            default: rate = 921600;
        endcase
        return 1_000_000_000 / rate;
    endfunction

    // Reference parity: count ones in the character, then apply the mode rule.
    function automatic logic model_parity(input logic [7:0] d, input logic size8, input logic [1:0] mode);
        int ones = 0;
        for (int i = 0; i < (size8 ? 8 : 7); i++) begin
            ones += int'(d[i]);
        end
        case (mode)
            2'b11:   return (ones % 2) == 0;
            2'b10:   return (ones % 2) == 1;
            2'b01:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Bit-level line driver; also records what a correct receiver must report.
    task automatic send_frame(input logic [7:0] d, input logic size8, input logic pen,
                              input logic [1:0] pmode, input logic stop2, input logic flip_par,
                              input logic [1:0] low_stop, input int sel, input int gap_bits,
                              input logic scramble);
        int   bn = bit_ns(sel);
        logic driven_par;
        baud_sel      = 3'(sel);
        data_size     = size8;
        parity_en     = pen;
        parity_mode   = pmode;
        stop_bit_size = stop2;
        rx = 1'b0;
        if (scramble) begin
            #(bn / 2);
            baud_sel      = 3'($urandom);
            data_size     = 1'($urandom);
            parity_en     = 1'($urandom);
            parity_mode   = 2'($urandom);
            stop_bit_size = 1'($urandom);
            #(bn - bn / 2);
        end else begin
            #(bn);
        end
        for (int i = 0; i < (size8 ? 8 : 7); i++) begin
            rx = d[i];
            #(bn);
        end
        driven_par = model_parity(d, size8, pmode) ^ flip_par;
        if (pen) begin
            rx = driven_par;
            #(bn);
        end
        rx = ~low_stop[0];
        #(bn);
        if (stop2) begin
            rx = ~low_stop[1];
            #(bn);
        end
        rx = 1'b1;
        if (gap_bits > 0) #(bn * gap_bits);
        exp_data.push_back(size8 ? d : {1'b0, d[6:0]});
        exp_pe.push_back(pen && (driven_par != model_parity(d, size8, pmode)));
        exp_fe.push_back(low_stop[0] || (stop2 && low_stop[1]));
    endtask

    task automatic wait_frames(input int want);
        int waited = 0;
        while (got_data.size() < want && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic flush();
        exp_data.delete(); exp_pe.delete(); exp_fe.delete();
        got_data.delete(); got_pe.delete(); got_fe.delete();
        got_busy_at.delete(); got_busy_after.delete(); got_wide.delete();
    endtask

    task automatic test_reset();
        #23 rst = 1'b0;
        #50;
        total++; if (data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h want=00", data); end
        total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", valid); end
        total++; if (parity_error !== 1'b0) begin bad++; $display("[TB] FAIL reset_pe got=%b want=0", parity_error); end
        total++; if (frame_error !== 1'b0) begin bad++; $display("[TB] FAIL reset_fe got=%b want=0", frame_error); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        #17 rst = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_parity_good();
        flush();
        send_frame(8'hAA, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 4, 1, 1'b0);
        wait_frames(1);
        total++;
        if (got_data.size() != 1) begin bad++; $display("[TB] FAIL good_count got=%0d want=1", got_data.size()); end
        else begin
            total++; if (got_data[0] !== 8'hAA) begin bad++; $display("[TB] FAIL good_data got=%h want=aa", got_data[0]); end
            total++; if (got_pe[0] !== exp_pe[0]) begin bad++; $display("[TB] FAIL good_pe got=%b want=%b", got_pe[0], exp_pe[0]); end
            total++; if (got_fe[0] !== 1'b0) begin bad++; $display("[TB] FAIL good_fe got=%b want=0", got_fe[0]); end
            total++; if (got_busy_at[0] !== 1'b1) begin bad++; $display("[TB] FAIL good_busy_at_valid got=%b want=1", got_busy_at[0]); end
            total++; if (got_busy_after[0] !== 1'b0) begin bad++; $display("[TB] FAIL good_busy_after got=%b want=0", got_busy_after[0]); end
            total++; if (got_wide[0] !== 1'b0) begin bad++; $display("[TB] FAIL good_valid_width got=%b want=0", got_wide[0]); end
        end
    endtask

    task automatic test_parity_error();
        flush();
        send_frame(8'hAA, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 2'b00, 7, 2, 1'b0);
        send_frame(8'hAA, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 7, 2, 1'b0);
        wait_frames(2);
        total++;
        if (got_data.size() != 2) begin bad++; $display("[TB] FAIL perr_count got=%0d want=2", got_data.size()); end
        else foreach (exp_data[i]) begin
            total++; if (got_data[i] !== exp_data[i]) begin bad++; $display("[TB] FAIL perr_data[%0d] got=%h want=%h", i, got_data[i], exp_data[i]); end
            total++; if (got_pe[i] !== exp_pe[i]) begin bad++; $display("[TB] FAIL perr_pe[%0d] got=%b want=%b", i, got_pe[i], exp_pe[i]); end
            total++; if (got_fe[i] !== exp_fe[i]) begin bad++; $display("[TB] FAIL perr_fe[%0d] got=%b want=%b", i, got_fe[i], exp_fe[i]); end
        end
    endtask

    task automatic test_frame_error();
        flush();
        send_frame(8'h55, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b10, 7, 2, 1'b0);
        send_frame(8'hD5, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 7, 2, 1'b0);
        wait_frames(2);
        total++;
        if (got_data.size() != 2) begin bad++; $display("[TB] FAIL ferr_count got=%0d want=2", got_data.size()); end
        else foreach (exp_data[i]) begin
            total++; if (got_data[i] !== exp_data[i]) begin bad++; $display("[TB] FAIL ferr_data[%0d] got=%h want=%h", i, got_data[i], exp_data[i]); end
            total++; if (got_pe[i] !== exp_pe[i]) begin bad++; $display("[TB] FAIL ferr_pe[%0d] got=%b want=%b", i, got_pe[i], exp_pe[i]); end
            total++; if (got_fe[i] !== exp_fe[i]) begin bad++; $display("[TB] FAIL ferr_fe[%0d] got=%b want=%b", i, got_fe[i], exp_fe[i]); end
        end
    endtask

    task automatic test_glitch();
        int bn = bit_ns(7);
        flush();
        baud_sel = 3'd7;
        rx = 1'b0;
        #((bn / 16) * 5);
        rx = 1'b1;
        #(bn * 2);
        total++; if (got_data.size() != 0) begin bad++; $display("[TB] FAIL glitch_valid got=%0d want=0", got_data.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL glitch_busy got=%b want=0", busy); end
        send_frame(8'h3C, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 7, 2, 1'b0);
        wait_frames(1);
        total++;
        if (got_data.size() != 1) begin bad++; $display("[TB] FAIL glitch_count got=%0d want=1", got_data.size()); end
        else begin
            total++; if (got_data[0] !== exp_data[0]) begin bad++; $display("[TB] FAIL glitch_data got=%h want=%h", got_data[0], exp_data[0]); end
            total++; if (got_fe[0] !== exp_fe[0]) begin bad++; $display("[TB] FAIL glitch_fe got=%b want=%b", got_fe[0], exp_fe[0]); end
        end
    endtask

    task automatic test_enable_abort();
        int bn = bit_ns(7);
        flush();
        baud_sel = 3'd7; data_size = 1'b1; parity_en = 1'b0; stop_bit_size = 1'b0;
        rx = 1'b0;
        #(bn);
        rx = 1'b0; #(bn);
        rx = 1'b1; #(bn / 2);
        en = 1'b0;
        #(bn / 2);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy got=%b want=0", busy); end
        for (int i = 2; i < 8; i++) begin rx = 1'(i % 2); #(bn); end
        rx = 1'b1;
        #(bn * 2);
        en = 1'b1;
        #(bn);
        total++; if (got_data.size() != 0) begin bad++; $display("[TB] FAIL abort_valid got=%0d want=0", got_data.size()); end
        total++; if (data !== 8'h3C) begin bad++; $display("[TB] FAIL abort_data_held got=%h want=3c", data); end
    endtask

    task automatic test_break();
        int bn = bit_ns(7);
        flush();
        baud_sel = 3'd7; data_size = 1'b1; parity_en = 1'b0; stop_bit_size = 1'b0;
        rx = 1'b0;
        #(bn * 20);
        total++;
        if (got_data.size() != 1) begin bad++; $display("[TB] FAIL break_count got=%0d want=1", got_data.size()); end
        else begin
            total++; if (got_data[0] !== 8'h00) begin bad++; $display("[TB] FAIL break_data got=%h want=00", got_data[0]); end
            total++; if (got_pe[0] !== 1'b0) begin bad++; $display("[TB] FAIL break_pe got=%b want=0", got_pe[0]); end
            total++; if (got_fe[0] !== 1'b1) begin bad++; $display("[TB] FAIL break_fe got=%b want=1", got_fe[0]); end
        end
        rx = 1'b1;
        #(bn * 2);
        total++; if (got_data.size() != 1) begin bad++; $display("[TB] FAIL break_rearm got=%0d want=1", got_data.size()); end
        flush();
        send_frame(8'h96, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 7, 2, 1'b0);
        wait_frames(1);
        total++;
        if (got_data.size() != 1 || got_data[0] !== exp_data[0] || got_fe[0] !== 1'b0) begin
            bad++; $display("[TB] FAIL break_recover got_n=%0d want_n=1 want_data=%h", got_data.size(), exp_data[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int         bn = bit_ns(7);
        logic [7:0] frame = 8'hF0;
        flush();
        baud_sel = 3'd7; data_size = 1'b1; parity_en = 1'b0; stop_bit_size = 1'b0;
        rx = 1'b0; #(bn);
        rx = frame[0]; #(bn);
        rx = frame[1]; #(bn);
        rx = frame[2]; #(bn / 2);
        rst = 1'b0;
        #1;
        total++; if (data !== 8'h00) begin bad++; $display("[TB] FAIL rstmid_data got=%h want=00", data); end
        total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_valid got=%b want=0", valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy got=%b want=0", busy); end
        total++; if (frame_error !== 1'b0 || parity_error !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_flags got=%b%b want=00", parity_error, frame_error); end
        #(bn / 2 - 1);
        rx = frame[3]; #(bn / 2);
        rst = 1'b1;
        #(bn - bn / 2);
        for (int i = 4; i < 8; i++) begin rx = frame[i]; #(bn); end
        rx = 1'b1;
        #(bn * 3);
        total++; if (got_data.size() != 0) begin bad++; $display("[TB] FAIL rstmid_no_valid got=%0d want=0", got_data.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3] = '{8'h01, 8'h80, 8'hFF};
        flush();
        for (int m = 3; m >= 0; m--) begin
            for (int b = 0; b < 3; b++) begin
                send_frame(bytes[b], 1'b1, 1'b1, 2'(m), 1'b0, 1'b0, 2'b00, 7, 0, 1'b0);
            end
        end
        #(bit_ns(7) * 2);
        wait_frames(12);
        total++;
        if (got_data.size() != 12) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=12", got_data.size()); end
        else foreach (exp_data[i]) begin
            total++; if (got_data[i] !== exp_data[i]) begin bad++; $display("[TB] FAIL b2b_data[%0d] got=%h want=%h", i, got_data[i], exp_data[i]); end
            total++; if (got_pe[i] !== 1'b0 || got_fe[i] !== 1'b0) begin bad++; $display("[TB] FAIL b2b_flags[%0d] got=%b%b want=00", i, got_pe[i], got_fe[i]); end
        end
    endtask

    task automatic test_random();
        flush();
        for (int n = 0; n < 10; n++) begin
            logic       pen = 1'($urandom);
            logic       stop2 = 1'($urandom);
            logic       flip = pen && ($urandom_range(3) == 0);
            logic [1:0] low = ($urandom_range(3) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            int         gap = (low != 2'b00) ? int'($urandom_range(2, 1)) : int'($urandom_range(2));
            send_frame(8'($urandom), 1'($urandom), pen, 2'($urandom), stop2, flip, low,
                       int'($urandom_range(7, 6)), gap, 1'b1);
        end
        #(bit_ns(6) * 2);
        wait_frames(10);
        total++;
        if (got_data.size() != 10) begin bad++; $display("[TB] FAIL rand_count got=%0d want=10", got_data.size()); end
        else foreach (exp_data[i]) begin
            total++; if (got_data[i] !== exp_data[i]) begin bad++; $display("[TB] FAIL rand_data[%0d] got=%h want=%h", i, got_data[i], exp_data[i]); end
            total++; if (got_pe[i] !== exp_pe[i]) begin bad++; $display("[TB] FAIL rand_pe[%0d] got=%b want=%b", i, got_pe[i], exp_pe[i]); end
            total++; if (got_fe[i] !== exp_fe[i]) begin bad++; $display("[TB] FAIL rand_fe[%0d] got=%b want=%b", i, got_fe[i], exp_fe[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_parity_good();
        test_parity_error();
        test_frame_error();
        test_glitch();
        test_enable_abort();
        test_break();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
